// File: rtl/dmem_line_responder_if.sv
// Request/response bus between the L1 data cache controller (master) and the
// line-granular backing memory (slave). One 256-bit line per transaction.
interface dmem_line_responder_if #(
    parameter int LINE_W = 256
);
    logic              enable;
    logic              write;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata;
    logic              ack;
    logic [LINE_W-1:0] rdata;
    logic              busy;
    logic              proto_err;

    modport master (
        output enable, write, addr, wdata,
        input  ack, rdata, busy, proto_err
    );

    modport slave (
        input  enable, write, addr, wdata,
        output ack, rdata, busy, proto_err
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Backing data memory answering cache line refills/write-backs after a fixed LATENCY.
// Optional sticky protocol checker on the held request: define DMEM_PROTOCOL_CHECK_EN.
module dmem_line_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_line_responder_if.slave  bus
);
    localparam int       LINES    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_q, state_nxt;
    logic [7:0]            cnt_q;
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [255:0]          wdata_q;
    logic [255:0]          rdata_q;
    logic [DEPTH_LOG2-1:0] line_idx;
    logic                  last;

    logic [255:0] mem [LINES];

    // Byte offset bits and everything above the line index are ignored, so addresses wrap.
    assign line_idx = bus.addr[DEPTH_LOG2+4:5];
    assign last     = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (bus.enable) state_nxt = S_WAIT;
            S_WAIT:  if (last)       state_nxt = S_ACK;
            S_ACK:                   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                S_IDLE: if (bus.enable) begin
                    wr_q    <= bus.write;
                    idx_q   <= line_idx;
                    wdata_q <= bus.wdata;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (last && !wr_q) rdata_q <= mem[idx_q];
                end
                default: ;
            endcase
        end
    end

    // Array contents survive reset; a reset during WAIT forces IDLE before the commit edge.
    always_ff @(posedge clk_i) begin
        if (last && wr_q) mem[idx_q] <= wdata_q;
    end

    assign bus.ack   = (state_q == S_ACK);
    assign bus.busy  = (state_q == S_WAIT);
    assign bus.rdata = rdata_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic proto_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            proto_q <= 1'b0;
        else if (state_q == S_WAIT &&
                 (!bus.enable || bus.write != wr_q || line_idx != idx_q))
            proto_q <= 1'b1;
    end
    assign bus.proto_err = proto_q;
`else
    assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed + randomized bench for dmem_line_responder against a line-array reference model.
module tb_dmem_line_responder;
    localparam int LAT = 10;
    localparam int DL  = 9;
    localparam int NL  = 1 << DL;

`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam bit EXP_PE = 1'b1;
`else
    localparam bit EXP_PE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [255:0] ref_mem [NL];
    bit           ref_vld [NL];

    dmem_line_responder_if #(.LINE_W(256)) bus ();

    dmem_line_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 5) % NL);
    endfunction

    // Issue one request from a negedge in IDLE; returns just after the negedge following ack.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                          input string tag);
        int n;
        bit got;
        logic [255:0] rd;
        bus.enable = 1'b1; bus.write = wr; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (bus.ack) got = 1'b1;
        end
        chk({tag, "_ack_seen"}, 256'(got), 256'(1));
        chk({tag, "_latency"}, 256'(n), 256'(LAT + 1));
        chk({tag, "_busy_in_ack"}, 256'(bus.busy), 256'(0));
        rd = bus.rdata;
        if (wr) begin
            ref_mem[idx_of(a)] = d;
            ref_vld[idx_of(a)] = 1'b1;
        end else begin
            chk({tag, "_rdata"}, rd, ref_mem[idx_of(a)]);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_width"}, 256'(bus.ack), 256'(0));
        chk({tag, "_rdata_hold"}, bus.rdata, rd);
    endtask

    initial begin
        logic [255:0] pa5, pp, pr, pq, p5, p6;
        int n;
        bit got;
        bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < NL; i++) ref_vld[i] = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ack", 256'(bus.ack), 256'(0));
            chk("idle_busy", 256'(bus.busy), 256'(0));
            chk("idle_rdata", bus.rdata, 256'(0));
        end
        chk("idle_proto", 256'(bus.proto_err), 256'(0));

        // Write/read A5 pattern
        pa5 = {32{8'hA5}};
        do_req(1'b1, 32'h0000_0040, pa5, "wr_a5");
        do_req(1'b0, 32'h0000_0040, '0, "rd_a5");
        chk("rd_a5_direct", bus.rdata, pa5);

        // Wrap and ignored offset bits
        pp = {8{32'h1234_5678 ^ 32'(8'h3C)}};
        pp[255:224] = 32'hDEAD_BEEF;
        do_req(1'b1, 32'h0000_0020, pp, "wr_p");
        do_req(1'b0, 32'h0000_4020, '0, "rd_wrap");
        chk("rd_wrap_direct", bus.rdata, pp);
        do_req(1'b0, 32'h0000_003F, '0, "rd_offs");
        chk("rd_offs_direct", bus.rdata, pp);

        // Back-to-back reads with enable held high
        bus.enable = 1'b1; bus.write = 1'b0; bus.addr = 32'h0000_0040;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < LAT + 20) begin
            @(negedge clk); n++;
            if (bus.ack) got = 1'b1;
        end
        chk("b2b_lat1", 256'(n), 256'(LAT + 1));
        chk("b2b_data1", bus.rdata, pa5);
        bus.addr = 32'h0000_0020;
        @(negedge clk);
        chk("b2b_gap_busy", 256'(bus.busy), 256'(0));
        chk("b2b_gap_ack", 256'(bus.ack), 256'(0));
        @(negedge clk);
        chk("b2b_second_busy", 256'(bus.busy), 256'(1));
        n = 1; got = 1'b0;
        while (!got && n < LAT + 20) begin
            @(negedge clk); n++;
            if (bus.ack) got = 1'b1;
        end
        chk("b2b_lat2", 256'(n), 256'(LAT + 1));
        chk("b2b_data2", bus.rdata, pp);
        bus.enable = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write: line 3 keeps its old contents
        pr = {8{$urandom}};
        pq = ~pr;
        do_req(1'b1, 32'h0000_0060, pr, "wr_r");
        bus.enable = 1'b1; bus.write = 1'b1; bus.addr = 32'h0000_0060; bus.wdata = pq;
        @(posedge clk);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack) got = 1'b1;
        end
        rst = 1'b0;
        #1;
        chk("abort_no_ack_before", 256'(got), 256'(0));
        chk("abort_ack", 256'(bus.ack), 256'(0));
        chk("abort_busy", 256'(bus.busy), 256'(0));
        chk("abort_rdata", bus.rdata, 256'(0));
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        got = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (bus.ack || bus.busy) got = 1'b1;
        end
        chk("abort_quiet_after", 256'(got), 256'(0));
        do_req(1'b0, 32'h0000_0060, '0, "rd_after_abort");
        chk("rd_after_abort_direct", bus.rdata, pr);
        chk("proto_clean", 256'(bus.proto_err), 256'(0));

        // Randomized traffic over lines 8..15 with random upper address bits
        for (int k = 0; k < 24; k++) begin
            int idx;
            bit wr;
            logic [31:0] a;
            idx = 8 + int'($urandom_range(0, 7));
            wr  = !ref_vld[idx] || ($urandom_range(0, 1) == 1);
            a   = ($urandom & 32'hFFFF_C000) | (32'(idx) << 5) | 32'($urandom_range(0, 31));
            do_req(wr, a, {8{$urandom}}, wr ? "rnd_wr" : "rnd_rd");
        end

        // Address change during WAIT
        p5 = {8{$urandom}};
        p6 = ~p5;
        do_req(1'b1, 32'h0000_00A0, p5, "wr_l5");
        do_req(1'b1, 32'h0000_00C0, p6, "wr_l6");
        chk("proto_pre", 256'(bus.proto_err), 256'(0));
        bus.enable = 1'b1; bus.write = 1'b0; bus.addr = 32'h0000_00A0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        bus.addr = 32'h0000_00C0;
        @(negedge clk);
        chk("proto_set", 256'(bus.proto_err), 256'(EXP_PE));
        n = 4; got = 1'b0;
        while (!got && n < LAT + 20) begin
            @(negedge clk); n++;
            if (bus.ack) got = 1'b1;
        end
        chk("proto_lat", 256'(n), 256'(LAT + 1));
        chk("proto_data", bus.rdata, p5);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("proto_sticky", 256'(bus.proto_err), 256'(EXP_PE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
